// File: rtl/if_id_queue.sv
// In-order fetch-to-decode buffer: reserves an entry per issued PC, fills it on ROM
// return, and presents completed {pc, inst} pairs to decode; flush drops owed returns.
module if_id_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_send_valid_i,
  input  logic [31:0] pc_ifu_i,
  output logic        pc_ready_o,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_data_i,
  input  logic        flush_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  input  logic        id_ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    FULL    = 2'd2
  } ent_state_e;

  ent_state_e               state_q [DEPTH];
  ent_state_e               state_d [DEPTH];
  logic [DEPTH-1:0][31:0]   pc_q, pc_d;
  logic [DEPTH-1:0][31:0]   inst_q, inst_d;
  logic [PW-1:0]            alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]            fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]            pop_ptr_q, pop_ptr_d;
  logic [DW-1:0]            drop_cnt_q, drop_cnt_d;

  logic [DW-1:0]            used_cnt;
  logic [DW-1:0]            pending_cnt;
  logic [DW-1:0]            drop_sum;
  logic [DW:0]              outstanding;
  logic                     issue;
  logic                     pop;
  logic                     fill;

  always_comb begin
    used_cnt    = '0;
    pending_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (state_q[i] != EMPTY)   used_cnt    = used_cnt + DW'(1);
      if (state_q[i] == PENDING) pending_cnt = pending_cnt + DW'(1);
    end
  end

  // Outstanding ROM requests = live entries plus returns still owed from a flush.
  assign outstanding = (DW+1)'(used_cnt) + (DW+1)'(drop_cnt_q);
  assign pc_ready_o  = !flush_i && (outstanding < (DW+1)'(DEPTH));
  assign id_valid_o  = (state_q[pop_ptr_q] == FULL) && !flush_i;
  assign id_pc_o     = pc_q[pop_ptr_q];
  assign id_inst_o   = inst_q[pop_ptr_q];

  assign issue    = pc_send_valid_i && pc_ready_o;
  assign pop      = id_valid_o && id_ready_i;
  // A return with nothing pending is a protocol error and is ignored.
  assign fill     = inst_valid_i && (drop_cnt_q == '0) && (state_q[fill_ptr_q] == PENDING);
  assign drop_sum = drop_cnt_q + pending_cnt;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    pop_ptr_d   = pop_ptr_q;
    drop_cnt_d  = drop_cnt_q;

    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) state_d[i] = EMPTY;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      pop_ptr_d   = '0;
      drop_cnt_d  = (inst_valid_i && drop_sum != '0) ? drop_sum - DW'(1) : drop_sum;
    end else begin
      // Popped, filled and allocated entries are distinct because allocation
      // only targets an entry that was EMPTY in registered state.
      if (pop) begin
        state_d[pop_ptr_q] = EMPTY;
        pop_ptr_d          = pop_ptr_q + PW'(1);
      end
      if (inst_valid_i && drop_cnt_q != '0) begin
        drop_cnt_d = drop_cnt_q - DW'(1);
      end else if (fill) begin
        state_d[fill_ptr_q] = FULL;
        inst_d[fill_ptr_q]  = inst_data_i;
        fill_ptr_d          = fill_ptr_q + PW'(1);
      end
      if (issue) begin
        state_d[alloc_ptr_q] = PENDING;
        pc_d[alloc_ptr_q]    = pc_ifu_i;
        alloc_ptr_d          = alloc_ptr_q + PW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: entry storage is reset too, because the head pair is visible on the
      // outputs even while invalid and must read as zero out of reset.
      state_q     <= '{default: EMPTY};
      pc_q        <= '0;
      inst_q      <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      pop_ptr_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      pop_ptr_q   <= pop_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a transaction model predicts ready/valid each cycle
// and a scoreboard queue holds the {pc, inst} pairs decode must receive, in order.
module tb_if_id_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_send_valid_i = 1'b0;
  logic [31:0] pc_ifu_i = '0;
  logic        pc_ready_o;
  logic        inst_valid_i = 1'b0;
  logic [31:0] inst_data_i = '0;
  logic        flush_i = 1'b0;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [31:0] pend_q [$];
  logic [63:0] exp_q  [$];
  int          drop_m = 0;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_send_valid_i (pc_send_valid_i),
    .pc_ifu_i        (pc_ifu_i),
    .pc_ready_o      (pc_ready_o),
    .inst_valid_i    (inst_valid_i),
    .inst_data_i     (inst_data_i),
    .flush_i         (flush_i),
    .id_valid_o      (id_valid_o),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_ready_i      (id_ready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, compare the model's view
  // of ready/valid/head before the rising edge, then advance the model.
  task automatic step(input bit iss, input logic [31:0] pc, input bit ret,
                      input logic [31:0] inst, input bit rdy, input bit fl);
    bit acc;
    bit popped;
    pc_send_valid_i = iss;
    pc_ifu_i        = pc;
    inst_valid_i    = ret;
    inst_data_i     = inst;
    id_ready_i      = rdy;
    flush_i         = fl;
    #1;
    acc    = !fl && ((pend_q.size() + exp_q.size() + drop_m) < DEPTH);
    check("pc_ready", 64'(pc_ready_o), 64'(acc));
    check("id_valid", 64'(id_valid_o), 64'(!fl && exp_q.size() > 0));
    acc    = acc && iss;
    popped = rdy && !fl && exp_q.size() > 0;
    if (popped)
      check("pop_pair", {id_pc_o, id_inst_o}, exp_q.pop_front());
    else if (!fl && exp_q.size() > 0)
      check("head_hold", {id_pc_o, id_inst_o}, exp_q[0]);
    if (fl) begin
      drop_m = drop_m + pend_q.size() - ((ret && (drop_m + pend_q.size()) > 0) ? 1 : 0);
      pend_q.delete();
      exp_q.delete();
    end else begin
      if (ret) begin
        if (drop_m > 0) drop_m--;
        else if (pend_q.size() > 0) exp_q.push_back({pend_q.pop_front(), inst});
      end
      if (acc) pend_q.push_back(pc);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_pc_ready", 64'(pc_ready_o), 64'd1);
    check("rst_id_valid", 64'(id_valid_o), 64'd0);
    check("rst_id_pc",    64'(id_pc_o),    64'd0);
    check("rst_id_inst",  64'(id_inst_o),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch
    step(1, 32'h0, 0, 32'h0,        1, 0);
    step(0, 32'h0, 0, 32'h0,        1, 0);
    step(0, 32'h0, 1, 32'h00000013, 1, 0);
    step(0, 32'h0, 0, 32'h0,        1, 0);
    step(0, 32'h0, 0, 32'h0,        1, 0);

    // Fill and backpressure
    step(1, 32'h0, 0, 32'h0,        0, 0);
    step(1, 32'h4, 1, 32'h11110000, 0, 0);
    step(1, 32'h8, 1, 32'h11110004, 0, 0);
    step(1, 32'hC, 1, 32'h11110008, 0, 0);
    step(1, 32'h10, 1, 32'h1111000C, 0, 0);
    check("full_not_ready", 64'(pc_ready_o), 64'd0);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 0, 32'h0, 1, 0);

    // Flush with two requests in flight
    step(1, 32'h0, 0, 32'h0, 0, 0);
    step(1, 32'h4, 0, 32'h0, 0, 0);
    step(0, 32'h0, 0, 32'h0, 0, 1);
    check("drop_cnt_2", 64'(dut.drop_cnt_q), 64'd2);
    step(0, 32'h0,   1, 32'hDEAD0000, 1, 0);
    step(0, 32'h0,   1, 32'hDEAD0004, 1, 0);
    step(1, 32'h100, 0, 32'h0,        1, 0);
    step(0, 32'h0,   1, 32'hAAAA5555, 1, 0);
    step(0, 32'h0,   0, 32'h0,        1, 0);
    step(0, 32'h0,   0, 32'h0,        1, 0);

    // Flush coinciding with a return
    step(1, 32'h200, 0, 32'h0, 0, 0);
    step(1, 32'h204, 0, 32'h0, 0, 0);
    step(0, 32'h0,   1, 32'hBEEF0200, 0, 1);
    check("drop_cnt_1", 64'(dut.drop_cnt_q), 64'd1);
    step(1, 32'h300, 1, 32'hBEEF0204, 1, 0);
    step(0, 32'h0,   1, 32'h33330300, 1, 0);
    step(0, 32'h0,   0, 32'h0,        1, 0);
    step(0, 32'h0,   0, 32'h0,        1, 0);

    // Wrap-around: back-to-back issue/return/pop; a bubble shows as an id_valid miss
    for (int k = 0; k < 12; k++) begin
      step(k < 10, 32'(4 * k), (k >= 1) && (k <= 10), 32'h5A000000 | 32'(k - 1), 1, 0);
    end
    step(0, 32'h0, 0, 32'h0, 1, 0);

    // Reset mid-operation with three FULL entries
    step(1, 32'h40, 0, 32'h0,        0, 0);
    step(1, 32'h44, 1, 32'h77770040, 0, 0);
    step(1, 32'h48, 1, 32'h77770044, 0, 0);
    step(0, 32'h0,  1, 32'h77770048, 0, 0);
    check("pre_rst_valid", 64'(id_valid_o), 64'd1);
    pc_send_valid_i = 1'b0;
    inst_valid_i    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_id_valid", 64'(id_valid_o), 64'd0);
    check("midrst_id_pc",    64'(id_pc_o),    64'd0);
    check("midrst_id_inst",  64'(id_inst_o),  64'd0);
    pend_q.delete();
    exp_q.delete();
    drop_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_ready", 64'(pc_ready_o), 64'd1);
    step(1, 32'h80, 0, 32'h0,        1, 0);
    step(0, 32'h0,  1, 32'h99990080, 1, 0);
    step(0, 32'h0,  0, 32'h0,        1, 0);
    step(0, 32'h0,  0, 32'h0,        1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

In-order fetch-to-decode buffer between the instruction fetch unit and the decode stage. It reserves an entry for each PC the fetch unit issues to instruction ROM and fills that entry when the instruction returns. It presents completed {pc, inst} pairs to decode with a valid/ready handshake. A flush discards all buffered and in-flight fetches.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_send_valid_i  input  1  fetch unit is issuing a request this cycle.
- pc_ifu_i  input  32  address of the issued request.
- pc_ready_o  output  1  a request may be issued; an issue is accepted when pc_send_valid_i & pc_ready_o.
- inst_valid_i  input  1  ROM returns one instruction; returns are in issue order.
- inst_data_i  input  32  returned instruction.
- flush_i  input  1  jump/redirect; discard everything older than the next issue.
- id_valid_o  output  1  head pair is available to decode.
- id_pc_o  output  32  PC of head pair.
- id_inst_o  output  32  instruction of head pair.
- id_ready_i  input  1  decode accepts; a pop occurs when id_valid_o & id_ready_i.

## Operation
- Each entry is in one of three states: EMPTY, PENDING (pc stored, awaiting inst) or FULL (pc+inst).
- alloc_ptr, fill_ptr and pop_ptr are each log2(DEPTH) bits and wrap modulo DEPTH.
- used = entries not EMPTY.
- drop_cnt (log2(DEPTH)+1 bits) counts returns still owed for flushed requests.
- pc_ready_o = !flush_i && (used + drop_cnt) < DEPTH. Outstanding ROM requests therefore never exceed DEPTH.
- Issue accepted: entry[alloc_ptr] goes EMPTY→PENDING and stores pc_ifu_i; alloc_ptr+1.
- Return with drop_cnt≠0: data discarded; drop_cnt−1; no entry changes.
- Return with drop_cnt=0: entry[fill_ptr] goes PENDING→FULL and stores inst_data_i; fill_ptr+1.
- A return with drop_cnt=0 and no PENDING entry is a protocol error. Ignore it and change no state.
- id_valid_o = entry[pop_ptr] FULL && !flush_i. id_pc_o and id_inst_o are driven from entry[pop_ptr] storage regardless of valid.
- Pop: entry[pop_ptr] goes FULL→EMPTY; pop_ptr+1.
- Flush (flush_i=1):
  - Every entry goes to EMPTY and all three pointers go to 0.
  - drop_cnt_next = drop_cnt + (#PENDING entries) − (1 if a return arrives this cycle).
  - No issue is accepted (pc_ready_o low) and no pop occurs (id_valid_o low).
- Simultaneous issue, return and pop in one non-flush cycle are all applied. An entry may be popped and re-allocated in the same cycle only if it was EMPTY at cycle start; allocation is gated by registered state only.

## Timing
- Reset (async assert) takes effect immediately:
  - all entries EMPTY, pointers 0, drop_cnt 0, storage 0.
  - pc_ready_o=1, id_valid_o=0, id_pc_o=0, id_inst_o=0.
- Reset deassertion is synchronous to clk. The first issue can be accepted on the first edge after release.
- Fetch latency: a return sampled at edge N makes id_valid_o high after edge N, if that entry is head. There is no combinational inst_valid_i→id_valid_o path.
- Throughput: one issue, one return and one pop per cycle sustained once the pipe is primed.
- pc_ready_o depends on flush_i and registered state only; it has no combinational path from pc_send_valid_i, inst_valid_i or id_ready_i.
- id_valid_o stays high until popped; id_pc_o and id_inst_o are stable while id_valid_o=1 and id_ready_i=0.
- Reset mid-operation discards all entries and owed returns. ROM returns after reset are accepted as normal (the system resets ROM together with this block).

## Test plan
- Single fetch: issue pc=0x0 at cycle 1, return 0x00000013 at cycle 3, id_ready_i=1 → id_valid_o=1 in cycle 4 with pc=0x0 and inst=0x00000013; id_valid_o=0 in cycle 5.
- Fill/backpressure: id_ready_i=0, issue pcs 0x0,0x4,0x8,0xC with returns → pc_ready_o=0 after the 4th issue. Raise id_ready_i → pairs pop in order 0x0…0xC, and pc_ready_o rises the cycle after the first pop.
- Flush with in-flight requests: issue 0x0,0x4 with no returns, flush_i pulse → drop_cnt=2. The next two returns are discarded. An issue of 0x100 followed by return 0xAAAA5555 → decode receives only {0x100, 0xAAAA5555}.
- Flush coinciding with a return: two PENDING entries, flush_i and inst_valid_i in the same cycle → drop_cnt=1; exactly one further return is discarded.
- Wrap-around: 10 back-to-back issue/return/pop transactions with id_ready_i=1 → PCs 0x0…0x24 emerge in order with matching instructions, and there are no bubbles after priming.
- Reset mid-operation: 3 FULL entries, assert rst_n=0 asynchronously mid-cycle → id_valid_o=0 and outputs=0 immediately; pc_ready_o=1 after release.
